// File: rtl/xif_alu_coproc_if.sv
// eXtension-interface bundle between core and ALU coprocessor:
// issue, commit and result channels.
interface xif_alu_coproc_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_req_instr;
  logic [X_ID_WIDTH-1:0] issue_req_id;
  logic [2*XLEN-1:0]     issue_req_rs;
  logic [1:0]            issue_req_rs_valid;
  logic                  issue_resp_accept;
  logic                  issue_resp_writeback;
  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;
  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [XLEN-1:0]       result_data;
  logic [4:0]            result_rd;
  logic                  result_we;

  modport master (
    output issue_valid, issue_req_instr,
    output issue_req_id, issue_req_rs,
    output issue_req_rs_valid,
    input  issue_ready, issue_resp_accept,
    input  issue_resp_writeback,
    output commit_valid, commit_id, commit_kill,
    input  result_valid, result_id,
    input  result_data, result_rd, result_we,
    output result_ready
  );

  modport slave (
    input  issue_valid, issue_req_instr,
    input  issue_req_id, issue_req_rs,
    input  issue_req_rs_valid,
    output issue_ready, issue_resp_accept,
    output issue_resp_writeback,
    input  commit_valid, commit_id, commit_kill,
    output result_valid, result_id,
    output result_data, result_rd, result_we,
    input  result_ready
  );
endinterface

// File: rtl/xif_alu_coproc.sv
// Pipelined CV-X-IF ALU coprocessor with an in-order speculative table.
// XIF_COPROC_POPCNT_EN adds the POPCNT op (funct3 100).
module xif_alu_coproc #(
  parameter int         X_ID_WIDTH = 4,
  parameter int         XLEN       = 32,
  parameter int         DEPTH      = 4,
  parameter logic [6:0] OPCODE     = 7'h0B,
  parameter logic [31:0] MAGIC     = 32'hDEADBEEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  xif_alu_coproc_if.slave xif,
  output logic            busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(XLEN);

  logic [X_ID_WIDTH-1:0] r_id   [DEPTH];
  logic [4:0]            r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [DEPTH-1:0]      r_cmt;
  logic [DEPTH-1:0]      r_kil;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_cnt;

  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_res;
  logic [2:0]      w_f3;
  logic            w_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_rv;
  logic            w_hit;
  logic            w_new_hit;
  logic [PW-1:0]   w_sel;
  logic            w_unused;

  assign w_rs1    = xif.issue_req_rs[XLEN-1:0];
  assign w_rs2    = xif.issue_req_rs[2*XLEN-1:XLEN];
  assign w_f3     = xif.issue_req_instr[14:12];
  assign w_unused = ^xif.issue_req_instr[31:15];

  always_comb begin
    w_ok  = 1'b0;
    w_res = '0;
    if (xif.issue_req_instr[6:0] == OPCODE) begin
      unique case (1'b1)
        (w_f3 == 3'b000): begin
          w_ok  = 1'b1;
          w_res = w_rs1 + w_rs2;
        end
        (w_f3 == 3'b001): begin
          w_ok  = 1'b1;
          w_res = w_rs1 ^ w_rs2;
        end
        (w_f3 == 3'b010): begin
          w_ok  = 1'b1;
          w_res = w_rs1 << w_rs2[SW-1:0];
        end
        (w_f3 == 3'b011): begin
          w_ok  = 1'b1;
          w_res = XLEN'(MAGIC);
        end
`ifdef XIF_COPROC_POPCNT_EN
        (w_f3 == 3'b100): begin
          w_ok  = 1'b1;
          w_res = XLEN'($countones(w_rs1));
        end
`endif
        default: ;
      endcase
    end
  end

  // full table blocks issue even when the head pops this cycle
  assign xif.issue_ready = (r_cnt != (PW+1)'(DEPTH))
                         && (&xif.issue_req_rs_valid);
  assign w_push = xif.issue_valid && xif.issue_ready && w_ok;
  assign xif.issue_resp_accept    = w_push;
  assign xif.issue_resp_writeback = w_push;

  assign w_empty = (r_cnt == '0);
  assign w_rv    = !w_empty && r_cmt[r_head] && !r_kil[r_head];
  assign w_pop   = !w_empty
                 && (r_kil[r_head] || (w_rv && xif.result_ready));

  assign xif.result_valid = w_rv;
  assign xif.result_we    = w_rv;
  assign xif.result_id    = w_rv ? r_id[r_head]   : '0;
  assign xif.result_data  = w_rv ? r_data[r_head] : '0;
  assign xif.result_rd    = w_rv ? r_rd[r_head]   : '0;
  assign busy_o           = !w_empty;

  // oldest pending match wins; the entry pushed now is youngest
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    w_hit = 1'b0;
    w_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PW'(k);
      if (!w_hit && xif.commit_valid
          && ((PW+1)'(k) < r_cnt)
          && (r_id[idx] == xif.commit_id)
          && !r_cmt[idx] && !r_kil[idx]) begin
        w_hit = 1'b1;
        w_sel = idx;
      end
    end
    w_new_hit = xif.commit_valid && !w_hit && w_push
              && (xif.issue_req_id == xif.commit_id);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_cmt  <= '0;
      r_kil  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]   <= '0;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_id[r_tail]   <= xif.issue_req_id;
        r_rd[r_tail]   <= xif.issue_req_instr[11:7];
        r_data[r_tail] <= w_res;
        r_cmt[r_tail]  <= w_new_hit && !xif.commit_kill;
        r_kil[r_tail]  <= w_new_hit && xif.commit_kill;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_hit) begin
        if (xif.commit_kill) r_kil[w_sel] <= 1'b1;
        else                 r_cmt[w_sel] <= 1'b1;
      end
      if (w_pop) r_head <= r_head + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xif_alu_coproc.sv
// Randomized self-checking bench for xif_alu_coproc against a
// queue-based reference model of the in-order result table.
module tb_xif_alu_coproc;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          cmt;
    bit          kil;
  } ent_t;
  ent_t mq[$];

  xif_alu_coproc_if xif ();

  xif_alu_coproc dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .xif    (xif),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(
    input  logic [31:0] ins,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output bit          ok,
    output logic [31:0] d
  );
    int sh;
    ok = 1'b0;
    d  = '0;
    sh = int'(b % 32);
    if (ins[6:0] == 7'h0B) begin
      case (ins[14:12])
        3'd0: begin ok = 1'b1; d = a + b; end
        3'd1: begin ok = 1'b1; d = a ^ b; end
        3'd2: begin ok = 1'b1; d = a * (32'd1 << sh); end
        3'd3: begin ok = 1'b1; d = 32'hDEADBEEF; end
`ifdef XIF_COPROC_POPCNT_EN
        3'd4: begin
          ok = 1'b1;
          for (int i = 0; i < 32; i++) d = d + 32'(a[i]);
        end
`endif
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] mk(logic [2:0] f3, logic [4:0] rd);
    return {17'h0, f3, rd, 7'h0B};
  endfunction

  task automatic cyc(
    bit iv, logic [31:0] ins, logic [3:0] id,
    logic [31:0] a, logic [31:0] b, logic [1:0] rsv,
    bit cv, logic [3:0] cid, bit ck, bit rr
  );
    bit ok, erdy, eacc, erv, pop, hit;
    logic [31:0] d;
    ent_t e;
    @(negedge clk_i);
    xif.issue_valid        = iv;
    xif.issue_req_instr    = ins;
    xif.issue_req_id       = id;
    xif.issue_req_rs       = {b, a};
    xif.issue_req_rs_valid = rsv;
    xif.commit_valid       = cv;
    xif.commit_id          = cid;
    xif.commit_kill        = ck;
    xif.result_ready       = rr;
    #1;
    ref_op(ins, a, b, ok, d);
    erdy = (mq.size() < 4) && (&rsv);
    eacc = iv && erdy && ok;
    erv  = (mq.size() > 0) && mq[0].cmt && !mq[0].kil;
    pop  = (mq.size() > 0) && (mq[0].kil || (erv && rr));
    chk("issue_ready", 32'(xif.issue_ready), 32'(erdy));
    chk("accept", 32'(xif.issue_resp_accept), 32'(eacc));
    chk("writeback", 32'(xif.issue_resp_writeback), 32'(eacc));
    chk("result_valid", 32'(xif.result_valid), 32'(erv));
    chk("result_we", 32'(xif.result_we), 32'(erv));
    chk("busy", 32'(busy_o), 32'(mq.size() > 0));
    if (erv) begin
      chk("result_id", 32'(xif.result_id), 32'(mq[0].id));
      chk("result_rd", 32'(xif.result_rd), 32'(mq[0].rd));
      chk("result_data", xif.result_data, mq[0].data);
    end
    @(posedge clk_i);
    hit = 1'b0;
    if (cv) begin
      foreach (mq[k]) begin
        if (!hit && mq[k].id == cid && !mq[k].cmt && !mq[k].kil) begin
          if (ck) mq[k].kil = 1'b1;
          else    mq[k].cmt = 1'b1;
          hit = 1'b1;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (eacc) begin
      e.id   = id;
      e.rd   = ins[11:7];
      e.data = d;
      e.cmt  = cv && !hit && (cid == id) && !ck;
      e.kil  = cv && !hit && (cid == id) && ck;
      mq.push_back(e);
    end
  endtask

  task automatic idle(bit rr);
    cyc(1'b0, '0, '0, '0, '0, 2'b11, 1'b0, '0, 1'b0, rr);
  endtask

  task automatic reset_check(string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_rv"}, 32'(xif.result_valid), 32'd0);
    chk({tag, "_we"}, 32'(xif.result_we), 32'd0);
    chk({tag, "_data"}, xif.result_data, 32'd0);
    chk({tag, "_id"}, 32'(xif.result_id), 32'd0);
    chk({tag, "_rd"}, 32'(xif.result_rd), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [3:0]  cid;
    logic [31:0] ins;
    xif.issue_valid        = 1'b0;
    xif.issue_req_instr    = '0;
    xif.issue_req_id       = '0;
    xif.issue_req_rs       = '0;
    xif.issue_req_rs_valid = 2'b11;
    xif.commit_valid       = 1'b0;
    xif.commit_id          = '0;
    xif.commit_kill        = 1'b0;
    xif.result_ready       = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_check("rst");
    chk("rst_ready", 32'(xif.issue_ready), 32'd1);
    rst_ni = 1'b1;

    // ADD with wrap-around
    cyc(1, mk(3'd0, 5'd10), 4'd3, 32'h5, 32'hFFFFFFFE, 2'b11,
        0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd3, 0, 1);
    idle(1);
    idle(1);

    // reserved funct3 is rejected
    cyc(1, mk(3'd7, 5'd4), 4'd6, 32'h1, 32'h2, 2'b11, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd6, 0, 1);
    idle(1);

    // fill the table, fifth issue must stall
    for (int i = 0; i < 4; i++)
      cyc(1, mk(3'd3, 5'(i + 1)), 4'(i), $urandom, $urandom, 2'b11,
          0, 0, 0, 1);
    cyc(1, mk(3'd3, 5'd9), 4'd9, 0, 0, 2'b11, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd0, 0, 1);
    idle(1);
    cyc(1, mk(3'd3, 5'd9), 4'd9, 0, 0, 2'b11, 1, 4'd1, 0, 1);
    for (int i = 2; i < 4; i++)
      cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'(i), 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd9, 0, 1);
    repeat (5) idle(1);

    // out-of-order commit, in-order results
    cyc(1, mk(3'd1, 5'd5), 4'd1, 32'hF0, 32'h0F, 2'b11, 0, 0, 0, 1);
    cyc(1, mk(3'd2, 5'd6), 4'd2, 32'h1, 32'd33, 2'b11, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd2, 0, 1);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd1, 0, 1);
    repeat (3) idle(1);

    // kill head, then hold a result with ready low
    cyc(1, mk(3'd0, 5'd7), 4'd4, 32'h10, 32'h20, 2'b11, 0, 0, 0, 0);
    cyc(1, mk(3'd1, 5'd8), 4'd5, 32'hAA, 32'h55, 2'b11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd4, 1, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd5, 0, 0);
    repeat (3) idle(0);
    repeat (2) idle(1);

    // operand not ready blocks issue
    cyc(1, mk(3'd0, 5'd1), 4'd2, 1, 1, 2'b01, 0, 0, 0, 1);

    // popcount op: accepted only when the option is built
    cyc(1, mk(3'd4, 5'd12), 4'd8, 32'hF0F00001, 0, 2'b11,
        1, 4'd8, 0, 1);
    repeat (2) idle(1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      f3  = 3'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 31));
      opc = ($urandom_range(0, 7) == 0) ? 7'h33 : 7'h0B;
      ins = {15'($urandom), 2'b00, f3, rd, opc};
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cid = mq[$urandom_range(0, mq.size() - 1)].id;
      else
        cid = 4'($urandom);
      cyc($urandom_range(0, 3) != 0, ins, 4'($urandom),
          $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11,
          $urandom_range(0, 2) != 0, cid,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0);
    end
    repeat (8) cyc(0, 0, 0, 0, 0, 2'b11, 0, 0, 1'b1, 1);
    mq.delete();
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;

    // reset with entries in flight and a valid head
    for (int i = 0; i < 3; i++)
      cyc(1, mk(3'd3, 5'd3), 4'(7 + i), 0, 0, 2'b11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 1, 4'd7, 0, 0);
    idle(0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    reset_check("midrst");
    chk("midrst_ready", 32'(xif.issue_ready), 32'd1);
    mq.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
